// File: rtl/core_alu_pkg.sv
// ---------------------------------------------------------------------------
// core_alu_pkg
// Shared constants for the multi-cycle execute-stage ALU:
//   - bit positions inside the one-hot req_op vector and its width
//   - FSM state encoding used by core_pipe_exec_alu_mc
// ---------------------------------------------------------------------------
package core_alu_pkg;

    localparam int ALU_OP_W    = 10;

    localparam int ALU_OP_ADD  = 0;
    localparam int ALU_OP_SUB  = 1;
    localparam int ALU_OP_XOR  = 2;
    localparam int ALU_OP_OR   = 3;
    localparam int ALU_OP_AND  = 4;
    localparam int ALU_OP_SLT  = 5;
    localparam int ALU_OP_SLTU = 6;
    localparam int ALU_OP_SRL  = 7;
    localparam int ALU_OP_SLL  = 8;
    localparam int ALU_OP_SRA  = 9;

    localparam logic [1:0] ALU_ST_IDLE  = 2'd0;
    localparam logic [1:0] ALU_ST_SHIFT = 2'd1;
    localparam logic [1:0] ALU_ST_DONE  = 2'd2;

endpackage

// File: rtl/core_alu_shift_step.sv
// ---------------------------------------------------------------------------
// core_alu_shift_step
// Combinational shift of val_i by amt_i bits (0..STEP), left or right.
// Right shifts fill with val_i's msb when arith_i is set, zeros otherwise.
//
// Ports:
//   val_i   [W-1:0]   value to shift
//   amt_i   [AW-1:0]  shift distance, 0..STEP
//   left_i            1 = shift left, 0 = shift right
//   arith_i           right shifts replicate the msb
//   res_o   [W-1:0]   shifted value
// ---------------------------------------------------------------------------
module core_alu_shift_step #(
    parameter int W    = 64,
    parameter int STEP = 8,
    parameter int AW   = $clog2(STEP + 1)
) (
    input  logic [W-1:0]  val_i,
    input  logic [AW-1:0] amt_i,
    input  logic          left_i,
    input  logic          arith_i,
    output logic [W-1:0]  res_o
);

    logic fill;
    logic [W-1:0] ones;

    always_comb begin
        fill = arith_i & val_i[W-1];
        ones = '1;
        if (left_i) begin
            res_o = val_i << amt_i;
        end else begin
            // The vacated upper bits are exactly those cleared in (ones >> amt).
            res_o = (val_i >> amt_i) | (fill ? ~(ones >> amt_i) : '0);
        end
    end

endmodule

// File: rtl/core_pipe_exec_alu_mc.sv
// ---------------------------------------------------------------------------
// core_pipe_exec_alu_mc
// Multi-cycle integer ALU for the execute stage with a req/rsp handshake and
// a registered result. add/sub/logic/compare complete in one cycle; shifts
// walk SHIFT_STEP bits per cycle through a single core_alu_shift_step.
//
// Build option: define CORE_ALU_FAST_SHIFT_EN to replace the iterative
// shifter with a log2(XLEN)-stage barrel shifter (every op latency 1, no
// SHIFT state, no remaining-amount counter).
//
// Ports:
//   g_clk, g_resetn        clock, synchronous active-low reset
//   flush                  drop in-flight op, block acceptance this cycle
//   req_valid/req_ready    request handshake
//   req_opr_a, req_opr_b   operands (B also carries the shift amount)
//   req_word               32-bit op with sign-extended result (XLEN=64)
//   req_op                 one-hot op select, see core_alu_pkg
//   rsp_valid/rsp_ready    response handshake
//   rsp_result             op result
//   rsp_add_out            raw full-width A+B / A-B
//   rsp_cmp_eq, rsp_cmp_lt comparison flags
//   busy                   FSM not idle
// ---------------------------------------------------------------------------
module core_pipe_exec_alu_mc
    import core_alu_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int SHIFT_STEP = 8
) (
    input  logic                g_clk,
    input  logic                g_resetn,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [XLEN-1:0]     req_opr_a,
    input  logic [XLEN-1:0]     req_opr_b,
    input  logic                req_word,
    input  logic [ALU_OP_W-1:0] req_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_result,
    output logic [XLEN-1:0]     rsp_add_out,
    output logic                rsp_cmp_eq,
    output logic                rsp_cmp_lt,
    output logic                busy
);

    localparam int SA_W = $clog2(XLEN);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    // ---------------- registered state ----------------
    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] res_q,   res_d;
    logic [XLEN-1:0] add_q,   add_d;
    logic            eq_q,    eq_d;
    logic            lt_q,    lt_d;

    // ---------------- request decode ----------------
    logic            word;
    logic            accept;
    logic            sub_op;
    logic            is_shift;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] add_res;
    logic            cmp_eq;
    logic            lts;
    logic            ltu;
    logic            cmp_lt;
    logic [XLEN-1:0] alu_res;
    logic [SA_W-1:0] sh_amt;
    logic [XLEN-1:0] sh_prep;
    logic [XLEN-1:0] sh_res;   // shift result when it completes on the accept edge
    logic            sh_go;    // shift needs the SHIFT state

    assign word      = req_word && (XLEN == 64);
    assign req_ready = !flush && ((state_q == ALU_ST_IDLE) ||
                                  ((state_q == ALU_ST_DONE) && rsp_ready));
    assign accept    = req_valid && req_ready;

    // slt/sltu also subtract so rsp_add_out shows A-B for them.
    assign sub_op   = req_op[ALU_OP_SUB] | req_op[ALU_OP_SLT] | req_op[ALU_OP_SLTU];
    assign is_shift = req_op[ALU_OP_SRL] | req_op[ALU_OP_SLL] | req_op[ALU_OP_SRA];
    assign sum      = req_opr_a + (sub_op ? ~req_opr_b : req_opr_b)
                    + {{(XLEN-1){1'b0}}, sub_op};
    assign add_res  = word ? sext32(sum[31:0]) : sum;

    always_comb begin
        if (word) begin
            cmp_eq = req_opr_a[31:0] == req_opr_b[31:0];
            lts    = $signed(req_opr_a[31:0]) < $signed(req_opr_b[31:0]);
            ltu    = req_opr_a[31:0] < req_opr_b[31:0];
        end else begin
            cmp_eq = req_opr_a == req_opr_b;
            lts    = $signed(req_opr_a) < $signed(req_opr_b);
            ltu    = req_opr_a < req_opr_b;
        end
        cmp_lt = req_op[ALU_OP_SLTU] ? ltu : lts;
    end

    // Terms are OR-ed; a zero op vector therefore yields 0.
    always_comb begin
        alu_res = '0;
        if (req_op[ALU_OP_ADD] | req_op[ALU_OP_SUB]) alu_res |= add_res;
        if (req_op[ALU_OP_XOR]) alu_res |= req_opr_a ^ req_opr_b;
        if (req_op[ALU_OP_OR])  alu_res |= req_opr_a | req_opr_b;
        if (req_op[ALU_OP_AND]) alu_res |= req_opr_a & req_opr_b;
        alu_res[0] = alu_res[0] | (req_op[ALU_OP_SLT] & lts) | (req_op[ALU_OP_SLTU] & ltu);
    end

    // Word shifts use 5 amount bits and a 32-bit source extended so that a
    // plain full-width shift gives the right low word.
    always_comb begin
        sh_amt = req_opr_b[SA_W-1:0];
        if (word) sh_amt[SA_W-1] = 1'b0;
        sh_prep = req_opr_a;
        if (word && !req_op[ALU_OP_SLL]) begin
            sh_prep = req_op[ALU_OP_SRA] ? sext32(req_opr_a[31:0]) : zext32(req_opr_a[31:0]);
        end
    end

`ifdef CORE_ALU_FAST_SHIFT_EN
    // Barrel: stage k shifts by 2^k when amount bit k is set.
    logic [XLEN-1:0] bar [SA_W+1];

    assign bar[0] = sh_prep;

    for (genvar k = 0; k < SA_W; k++) begin : g_bar
        logic [k:0] st_amt;
        always_comb begin
            st_amt    = '0;
            st_amt[k] = sh_amt[k];
        end
        core_alu_shift_step #(
            .W    (XLEN),
            .STEP (1 << k)
        ) u_stage (
            .val_i   (bar[k]),
            .amt_i   (st_amt),
            .left_i  (req_op[ALU_OP_SLL]),
            .arith_i (req_op[ALU_OP_SRA]),
            .res_o   (bar[k+1])
        );
    end

    assign sh_res = word ? sext32(bar[SA_W][31:0]) : bar[SA_W];
    assign sh_go  = 1'b0;
`else
    localparam logic [SA_W:0] STEP_L = (SA_W+1)'(SHIFT_STEP);

    logic [SA_W-1:0] rem_q,  rem_d;
    logic [XLEN-1:0] work_q, work_d;
    logic            shl_q,  shl_d;
    logic            sar_q,  sar_d;
    logic            wrd_q,  wrd_d;
    logic [SA_W:0]   rem_ext;
    logic            step_last;
    logic [SA_W:0]   step_w;
    logic [XLEN-1:0] step_res;

    // Zero-amount shifts complete straight from the prepared value.
    assign sh_res = word ? sext32(sh_prep[31:0]) : sh_prep;
    assign sh_go  = is_shift && (sh_amt != '0);

    assign rem_ext   = {1'b0, rem_q};
    assign step_last = rem_ext <= STEP_L;
    assign step_w    = step_last ? rem_ext : STEP_L;

    core_alu_shift_step #(
        .W    (XLEN),
        .STEP (SHIFT_STEP),
        .AW   (SA_W + 1)
    ) u_step (
        .val_i   (work_q),
        .amt_i   (step_w),
        .left_i  (shl_q),
        .arith_i (sar_q),
        .res_o   (step_res)
    );
`endif

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        add_d   = add_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
`ifndef CORE_ALU_FAST_SHIFT_EN
        rem_d   = rem_q;
        work_d  = work_q;
        shl_d   = shl_q;
        sar_d   = sar_q;
        wrd_d   = wrd_q;
`endif
        if (flush) begin
            // Result registers keep their last value; only the FSM is dropped.
            state_d = ALU_ST_IDLE;
        end else begin
`ifndef CORE_ALU_FAST_SHIFT_EN
            if (state_q == ALU_ST_SHIFT) begin
                work_d = step_res;
                rem_d  = rem_q - step_w[SA_W-1:0];
                if (step_last) begin
                    state_d = ALU_ST_DONE;
                    res_d   = wrd_q ? sext32(step_res[31:0]) : step_res;
                end
            end
`endif
            if ((state_q == ALU_ST_DONE) && rsp_ready) state_d = ALU_ST_IDLE;
            if (state_q == 2'd3) state_d = ALU_ST_IDLE;

            if (accept) begin
                add_d = sum;
                eq_d  = cmp_eq;
                lt_d  = cmp_lt;
                if (sh_go) begin
`ifndef CORE_ALU_FAST_SHIFT_EN
                    state_d = ALU_ST_SHIFT;
                    work_d  = sh_prep;
                    rem_d   = sh_amt;
                    shl_d   = req_op[ALU_OP_SLL];
                    sar_d   = req_op[ALU_OP_SRA];
                    wrd_d   = word;
`endif
                end else begin
                    state_d = ALU_ST_DONE;
                    res_d   = is_shift ? sh_res : alu_res;
                end
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ALU_ST_IDLE;
            res_q   <= '0;
            add_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
`ifndef CORE_ALU_FAST_SHIFT_EN
            rem_q   <= '0;
            work_q  <= '0;
            shl_q   <= 1'b0;
            sar_q   <= 1'b0;
            wrd_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            add_q   <= add_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
`ifndef CORE_ALU_FAST_SHIFT_EN
            rem_q   <= rem_d;
            work_q  <= work_d;
            shl_q   <= shl_d;
            sar_q   <= sar_d;
            wrd_q   <= wrd_d;
`endif
        end
    end

    assign rsp_valid   = state_q == ALU_ST_DONE;
    assign busy        = state_q != ALU_ST_IDLE;
    assign rsp_result  = res_q;
    assign rsp_add_out = add_q;
    assign rsp_cmp_eq  = eq_q;
    assign rsp_cmp_lt  = lt_q;

endmodule

// File: tb/tb_core_pipe_exec_alu_mc.sv
module tb_core_pipe_exec_alu_mc;
    import core_alu_pkg::*;

    localparam int XLEN = 64;

    logic            g_clk;
    logic            g_resetn;
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_opr_a;
    logic [XLEN-1:0] req_opr_b;
    logic            req_word;
    logic [ALU_OP_W-1:0] req_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic [XLEN-1:0] rsp_add_out;
    logic            rsp_cmp_eq;
    logic            rsp_cmp_lt;
    logic            busy;

    int checks = 0;
    int errors = 0;

    localparam logic [9:0] OP_ADD  = 10'b00_0000_0001;
    localparam logic [9:0] OP_SUB  = 10'b00_0000_0010;
    localparam logic [9:0] OP_XOR  = 10'b00_0000_0100;
    localparam logic [9:0] OP_OR   = 10'b00_0000_1000;
    localparam logic [9:0] OP_AND  = 10'b00_0001_0000;
    localparam logic [9:0] OP_SLT  = 10'b00_0010_0000;
    localparam logic [9:0] OP_SLTU = 10'b00_0100_0000;
    localparam logic [9:0] OP_SRL  = 10'b00_1000_0000;
    localparam logic [9:0] OP_SLL  = 10'b01_0000_0000;
    localparam logic [9:0] OP_SRA  = 10'b10_0000_0000;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    core_pipe_exec_alu_mc #(
        .XLEN       (XLEN),
        .SHIFT_STEP (8)
    ) dut (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opr_a   (req_opr_a),
        .req_opr_b   (req_opr_b),
        .req_word    (req_word),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_add_out (rsp_add_out),
        .rsp_cmp_eq  (rsp_cmp_eq),
        .rsp_cmp_lt  (rsp_cmp_lt),
        .busy        (busy)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic tick;
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one edge; it must be acceptable.
    task automatic issue(input string tag, input logic [9:0] op,
                         input logic [63:0] a, input logic [63:0] b, input logic w);
        if ($countones(op) > 1) $error("illegal multi-hot req_op %b in %s", op, tag);
        req_op    = op;
        req_opr_a = a;
        req_opr_b = b;
        req_word  = w;
        req_valid = 1'b1;
        #1;
        chk({tag, "_rdy"}, req_ready, 1);
        tick;
        req_valid = 1'b0;
    endtask

    // Called right after the accept edge; counts cycles until rsp_valid.
    task automatic wait_rsp(input string tag, input int exp_lat);
        int n;
        n = 1;
        while (!rsp_valid && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
    endtask

    initial begin
        logic seen;
        g_resetn  = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_opr_a = '0;
        req_opr_b = '0;
        req_word  = 1'b0;
        req_op    = '0;
        rsp_ready = 1'b1;

        // reset state
        tick;
        tick;
        chk("rst_valid",  rsp_valid, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_add",    rsp_add_out, 0);
        chk("rst_eq",     rsp_cmp_eq, 0);
        chk("rst_lt",     rsp_cmp_lt, 0);
        g_resetn = 1'b1;
        tick;
        chk("rst_ready",  req_ready, 1);

        // add wraps to zero, latency 1
        issue("add", OP_ADD, ONES, 64'd1, 1'b0);
        chk("add_valid", rsp_valid, 1);
        chk("add_res",   rsp_result, 0);
        chk("add_sum",   rsp_add_out, 0);
        chk("add_busy",  busy, 1);
        tick;
        chk("add_idle",  rsp_valid, 0);

        // sub word: 0 - 1 sign-extended
        issue("subw", OP_SUB, 64'd0, 64'd1, 1'b1);
        chk("subw_res", rsp_result, ONES);
        chk("subw_sum", rsp_add_out, ONES);
        tick;

        // compares: -2 vs 1
        issue("slt", OP_SLT, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0);
        chk("slt_res", rsp_result, 1);
        chk("slt_eq",  rsp_cmp_eq, 0);
        chk("slt_lt",  rsp_cmp_lt, 1);
        tick;
        issue("sltu", OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0);
        chk("sltu_res", rsp_result, 0);
        chk("sltu_lt",  rsp_cmp_lt, 0);
        tick;

        // sra by 63 in 8-bit steps: 1 + 8 cycles
        issue("sra63", OP_SRA, 64'h8000_0000_0000_0000, 64'd63, 1'b0);
        wait_rsp("sra63", 9);
        chk("sra63_res", rsp_result, ONES);
        tick;

        // srl word by 31: 1 + 4 cycles
        issue("srlw31", OP_SRL, 64'hDEAD_BEEF_8000_0000, 64'd31, 1'b1);
        wait_rsp("srlw31", 5);
        chk("srlw31_res", rsp_result, 64'd1);
        tick;

        // sll word by 31, result sign-extended from bit 31
        issue("sllw31", OP_SLL, 64'd1, 64'd31, 1'b1);
        wait_rsp("sllw31", 5);
        chk("sllw31_res", rsp_result, 64'hFFFF_FFFF_8000_0000);
        tick;

        // 64-bit sll uses B[5:0] only: 0x40 -> amount 0
        issue("sll64z", OP_SLL, 64'h1234, 64'h40, 1'b0);
        wait_rsp("sll64z", 1);
        chk("sll64z_res", rsp_result, 64'h1234);
        tick;

        // srl word by 0
        issue("srlw0", OP_SRL, 64'hDEAD_BEEF_8000_0000, 64'd0, 1'b1);
        wait_rsp("srlw0", 1);
        chk("srlw0_res", rsp_result, 64'hFFFF_FFFF_8000_0000);
        tick;

        // flush mid-shift
        issue("fl_sra", OP_SRA, 64'h8000_0000_0000_0000, 64'd63, 1'b0);
        chk("fl_busy1", busy, 1);
        tick;
        tick;
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_ADD;
        #1;
        chk("fl_ready", req_ready, 0);
        tick;
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("fl_busy0",  busy, 0);
        chk("fl_valid",  rsp_valid, 0);
        chk("fl_result", rsp_result, 64'hFFFF_FFFF_8000_0000);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            seen |= rsp_valid;
        end
        chk("fl_no_rsp", seen, 0);

        // reset held 2 cycles mid-shift
        issue("rs_sra", OP_SRA, 64'h8000_0000_0000_0000, 64'd63, 1'b0);
        tick;
        g_resetn = 1'b0;
        tick;
        tick;
        g_resetn = 1'b1;
        chk("rs_valid",  rsp_valid, 0);
        chk("rs_busy",   busy, 0);
        chk("rs_ready",  req_ready, 1);
        chk("rs_result", rsp_result, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            seen |= rsp_valid;
        end
        chk("rs_no_rsp", seen, 0);

        // backpressure then back-to-back accept
        rsp_ready = 1'b0;
        issue("bp_xor", OP_XOR, 64'hF0F0, 64'hFF00, 1'b0);
        chk("bp_res0", rsp_result, 64'h0FF0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_res",   rsp_result, 64'h0FF0);
            chk("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        req_op    = OP_ADD;
        req_opr_a = 64'd5;
        req_opr_b = 64'd3;
        req_word  = 1'b0;
        req_valid = 1'b1;
        #1;
        chk("b2b_ready", req_ready, 1);
        tick;
        req_valid = 1'b0;
        chk("b2b_valid", rsp_valid, 1);
        chk("b2b_res",   rsp_result, 64'd8);
        chk("b2b_sum",   rsp_add_out, 64'd8);
        tick;
        chk("b2b_idle",  rsp_valid, 0);
        chk("b2b_busy",  busy, 0);

        // no op bit set: result 0, compares still live
        issue("zop", 10'b0, 64'd7, 64'd7, 1'b0);
        chk("zop_res", rsp_result, 0);
        chk("zop_eq",  rsp_cmp_eq, 1);
        chk("zop_sum", rsp_add_out, 64'd14);
        tick;

        issue("or", OP_OR, 64'hC, 64'hA, 1'b0);
        chk("or_res", rsp_result, 64'hE);
        tick;
        issue("and", OP_AND, 64'hC, 64'hA, 1'b0);
        chk("and_res", rsp_result, 64'h8);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_pipe_exec_alu_mc.md
Name: core_pipe_exec_alu_mc

Overview:
- Parametrised, multi-cycle integer ALU for the execute stage. It is the successor to the single-cycle combinational ALU.
- Adds a request/response handshake and a registered result.
- Adds a complete SLT/SLTU and an SRL/SRA/SLL iterative shifter. The shifter moves at most SHIFT_STEP bits per cycle to shorten the critical path.
- Supports RV32 and RV64 through XLEN. Word (*W) ops are legal only when XLEN=64.

Parameters:
XLEN, 64, datapath width; 32 or 64 only.
SHIFT_STEP, 8, maximum shift distance per cycle; power of two, 1..XLEN.

Ports:
g_clk  in  1  clock
g_resetn  in  1  synchronous active-low reset
flush  in  1  abandon any in-flight op; highest priority after reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_opr_a  in  XLEN  operand A
req_opr_b  in  XLEN  operand B / shift amount
req_word  in  1  operate on low 32 bits, sign-extend result (XLEN=64 only)
req_op  in  10  one-hot: add,sub,xor,or,and,slt,sltu,srl,sll,sra (bit 0..9)
rsp_valid  out  1  result available
rsp_ready  in  1  result consumed when rsp_valid && rsp_ready
rsp_result  out  XLEN  operation result
rsp_add_out  out  XLEN  raw A+B or A-B sum (full width)
rsp_cmp_eq  out  1  A==B (low 32 bits when word)
rsp_cmp_lt  out  1  A<B; signed for slt/add/sub, unsigned for sltu
busy  out  1  state != IDLE

Behaviour:
- Reset (g_resetn low at a g_clk edge):
  - state=IDLE.
  - rsp_valid=0, rsp_result=0, rsp_add_out=0, rsp_cmp_eq=0, rsp_cmp_lt=0.
  - busy=0. req_ready=1 on the cycle after reset.
  - Reset mid-operation discards the op silently.
- States:
  - IDLE -> SHIFT: on accept of srl/sll/sra with nonzero amount.
  - IDLE -> DONE: on accept of any other op, or a shift with amount 0.
  - SHIFT -> DONE: when the remaining amount reaches 0.
  - DONE -> IDLE: when rsp_ready is high and no new request is accepted.
  - DONE -> SHIFT or DONE: when a new request is accepted in the same cycle that rsp_ready is high.
- req_ready = (state==IDLE) || (state==DONE && rsp_ready), and is forced low while flush is high.
- Non-shift ops: result is registered on the accept edge; rsp_valid=1 on the next cycle (latency 1).
- Add/sub:
  - sum = A + (sub ? ~B : B) + sub, modulo 2^XLEN.
  - word: result = sign-extend of sum[31:0].
- Bitwise: xor/or/and over the full width. The word flag is ignored.
- SLT/SLTU:
  - rsp_result = {0..., lt}.
  - signed lt = (A[msb]^B[msb]) ? A[msb] : sum[msb].
  - unsigned lt = borrow-out of A-B.
  - msb = 31 when word, else XLEN-1.
- Shifts:
  - Amount: amt = B[4:0] when word or XLEN=32, else B[5:0].
  - Working register preparation on accept:
    - sll: A.
    - srl: word ? zero-extend(A[31:0]) : A.
    - sra: word ? sign-extend(A[31:0]) : A.
  - Each SHIFT cycle shifts by min(rem, SHIFT_STEP) and decrements rem by the same value.
  - sra fills from the sign bit (bit 31 when word, else XLEN-1).
  - Word results are sign-extended from bit 31 when entering DONE.
  - Latency: 1 + ceil(amt/SHIFT_STEP) cycles from accept to rsp_valid.
- DONE:
  - rsp_* outputs are held stable while rsp_valid && !rsp_ready.
  - rsp_valid drops on the cycle after consumption, unless a back-to-back op completes in one cycle.
- flush:
  - Takes effect on the next edge: state=IDLE and rsp_valid=0.
  - Any request presented on the same cycle is not accepted.
  - rsp_result is not cleared.
- req_op with zero bits set: result is 0 and cmp outputs are still computed.
- More than one bit set in req_op is illegal: the result is undefined and the bench flags it.
- req_word with XLEN=32 is ignored.

Optional Feature:
CORE_ALU_FAST_SHIFT_EN
- Defined: shifts use a full log2(XLEN)-stage barrel shifter. Every op, including shifts of any amount, completes with latency 1. The SHIFT state and the rem counter are not instantiated.
- Undefined: the iterative SHIFT_STEP shifter described above is used.

Decomposition:
- Shared package core_alu_pkg holds:
  - The req_op bit-index constants (ALU_OP_ADD..ALU_OP_SRA) and the ALU_OP_W=10 width.
  - The state encoding (ALU_ST_IDLE, ALU_ST_SHIFT, ALU_ST_DONE).
- One sub-module, core_alu_shift_step: a combinational shift of a value by 0..SHIFT_STEP bits with direction and arithmetic-fill inputs. It is instantiated once in the iterative build and reused log2(XLEN) times in the fast build.

Test Plan:
- Reset and flush:
  - Reset held 2 cycles mid-SHIFT -> rsp_valid=0, busy=0, req_ready=1 the next cycle.
  - flush during SHIFT -> IDLE next cycle, no response.
- Add/sub: add with XLEN=64, A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> result=0, latency 1. Sub word with A=0, B=1 -> result=0xFFFF_FFFF_FFFF_FFFF.
- Compare: A=0xFFFF_FFFF_FFFF_FFFE, B=1. slt -> 1, sltu -> 0, cmp_eq=0.
- Arithmetic right shift: sra with A=0x8000_0000_0000_0000, B=63, SHIFT_STEP=8 -> result all ones, rsp_valid exactly 9 cycles after accept.
- Logical right shift, word: srl word with A=0xDEAD_BEEF_8000_0000, B=31 -> result=1. srl word with B=0 -> result=0xFFFF_FFFF_8000_0000.
- Backpressure: rsp_ready low 5 cycles -> outputs stable. Then rsp_ready=1 with req_valid=1 -> accept in the same cycle and a new result next cycle.
